memory_access_unit: RTL and testbench
=====================================

MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: data and memory bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64: byte address width.
REQ-003 SHALL have port i_clk  in  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_arst  in  1: reset, synchronous, active-high.
REQ-005 SHALL have port i_mem_re  in  1: load request from the memory-stage pipeline register.
REQ-006 SHALL have port i_mem_we  in  1: store request.
REQ-007 SHALL have port i_funct3  in  3: access size/sign (0 LB/SB, 1 LH/SH, 2 LW/SW, 3 LD/SD, 4 LBU, 5 LHU, 6 LWU).
REQ-008 SHALL have port i_addr  in  ADDR_WIDTH: byte address, i.e. the ALU result.
REQ-009 SHALL have port i_write_data  in  DATA_WIDTH: unshifted store data, rs2.
REQ-010 SHALL have port i_dmem_ready  in  1: memory accepted the request; on loads, i_dmem_rdata is valid.
REQ-011 SHALL have port i_dmem_rdata  in  DATA_WIDTH: 8-byte-aligned read doubleword.
REQ-012 SHALL have port o_dmem_req  out  1: request valid to data memory.
REQ-013 SHALL have port o_dmem_we  out  1: request is a store.
REQ-014 SHALL have port o_dmem_addr  out  ADDR_WIDTH: {i_addr[ADDR_WIDTH-1:3], 3'b0}.
REQ-015 SHALL have port o_dmem_be  out  8: byte enables.
REQ-016 SHALL have port o_dmem_wdata  out  DATA_WIDTH: lane-shifted store data.
REQ-017 SHALL have port o_read_data  out  DATA_WIDTH: extended load result, fed to the write-back pipeline register.
REQ-018 SHALL have port o_stall_mem  out  1: holds the memory stage and all upstream stages, and holds the write-back register.
REQ-019 SHALL have port o_misaligned  out  1: misaligned access detected.
REQ-020 SHALL have port o_cause  out  4: 4 = load misaligned, 6 = store misaligned, 0 = none.

Function
REQ-021 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-022 SHALL define op valid = i_mem_re | i_mem_we; when both are high, the access is a store.
REQ-023 SHALL define size = 1 << i_funct3[1:0] bytes; misaligned = op valid & (i_addr[2:0] mod size != 0).
REQ-024 SHALL, in IDLE, drive o_misaligned and o_cause combinationally from the current inputs; a misaligned op issues no request, raises no stall, and stays in IDLE.
REQ-025 SHALL, in IDLE with a valid aligned op, assert o_stall_mem combinationally, register addr/be/wdata/we/funct3/addr[2:0], and go to WAIT.
REQ-026 SHALL, in WAIT, assert o_dmem_req and o_stall_mem and hold the registered outputs stable until i_dmem_ready = 1.
REQ-027 SHALL, in WAIT with i_dmem_ready = 1, register o_read_data (loads only; stores leave it unchanged) and go to DONE.
REQ-028 SHALL, in DONE, deassert o_stall_mem and o_dmem_req, ignore the still-present inputs, and return to IDLE next cycle.
REQ-029 SHALL give a minimum load-to-data latency of 2 cycles, IDLE->WAIT->DONE, with o_read_data valid in DONE.
REQ-030 SHALL compute o_dmem_be = ((1<<size)-1) << addr[2:0] and o_dmem_wdata = i_write_data << (8*addr[2:0]).
REQ-031 SHALL compute the load result as r = i_dmem_rdata >> (8*addr[2:0]), truncated to size, sign-extended when funct3[2] = 0 and zero-extended otherwise; funct3 = 7 SHALL behave as 3.
REQ-032 SHALL drive o_dmem_req, o_dmem_we and o_dmem_be to 0 outside WAIT.

Reset
REQ-033 SHALL, with i_arst high at a rising edge, force IDLE and clear all registered outputs to 0, including mid-WAIT; o_dmem_req SHALL be 0 in the cycle after that edge.
REQ-034 SHALL keep o_stall_mem at 0 while i_arst is high.

Verification
REQ-035 SHALL cover: LB with addr 0x1003, rdata 0x0000_0000_80FF_0000, ready in the first WAIT cycle -> be 0x08, o_read_data 0xFFFF_FFFF_FFFF_FF80 in DONE, stall high for 2 cycles.
REQ-036 SHALL cover: SH with addr 0x2006, wdata 0x1234 -> be 0xC0, wdata 0x1234_0000_0000_0000, addr 0x2000, we = 1.
REQ-037 SHALL cover: LW with addr 0x3002 -> o_misaligned = 1, cause 4, no o_dmem_req, stall 0; SD with addr 0x3004 -> cause 6.
REQ-038 SHALL cover: LD with i_dmem_ready held low for 5 cycles -> req and stall high for 6 WAIT cycles with the address stable, then DONE.
REQ-039 SHALL cover: i_arst asserted in the 2nd WAIT cycle -> IDLE, req 0 and o_read_data 0 after the edge; a new LWU with addr 0x10 and rdata 0xFFFF_FFFF -> 0x0000_0000_FFFF_FFFF.

Source files
------------

// File: rtl/memory_access_unit.sv
// Memory-stage load/store unit: aligns store data and byte enables onto an 8-byte
// bus, handles a simple req/ready handshake and extends load results for write-back.
module memory_access_unit #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_mem_re,
    input  logic                  i_mem_we,
    input  logic [2:0]            i_funct3,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic                  i_dmem_ready,
    input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
    output logic                  o_dmem_req,
    output logic                  o_dmem_we,
    output logic [ADDR_WIDTH-1:0] o_dmem_addr,
    output logic [7:0]            o_dmem_be,
    output logic [DATA_WIDTH-1:0] o_dmem_wdata,
    output logic [DATA_WIDTH-1:0] o_read_data,
    output logic                  o_stall_mem,
    output logic                  o_misaligned,
    output logic [3:0]            o_cause,
    output logic [1:0]            state_dbg
);

    // Handshake: o_dmem_req is held with address/be/wdata stable until a cycle in
    // which i_dmem_ready is 1; that cycle completes the transfer (and carries rdata).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic [2:0]            funct3_q;
    logic [2:0]            off_q;
    logic [DATA_WIDTH-1:0] read_data_q;

    logic                  op_valid;
    logic [2:0]            off;
    logic [2:0]            align_mask;
    logic                  misaligned_now;
    logic [7:0]            be_now;
    logic [DATA_WIDTH-1:0] wdata_now;
    logic [DATA_WIDTH-1:0] rdata_shifted;
    logic [DATA_WIDTH-1:0] load_result;
    logic                  sign_fill;
    logic                  capture;
    logic                  load_capture;
    logic                  stall_raw;

    assign op_valid = i_mem_re | i_mem_we;
    assign off      = i_addr[2:0];

    always_comb begin
        align_mask = 3'b000;
        be_now     = 8'h01;
        case (i_funct3[1:0])
            2'd0: begin align_mask = 3'b000; be_now = 8'h01; end
            2'd1: begin align_mask = 3'b001; be_now = 8'h03; end
            2'd2: begin align_mask = 3'b011; be_now = 8'h0F; end
            default: begin align_mask = 3'b111; be_now = 8'hFF; end
        endcase
        be_now = be_now << off;
    end

    assign misaligned_now = op_valid & (|(off & align_mask));
    assign wdata_now      = i_write_data << {off, 3'b000};

    // Load extraction uses the offset and size captured at request time.
    assign rdata_shifted = i_dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        sign_fill   = 1'b0;
        load_result = rdata_shifted;
        case (funct3_q[1:0])
            2'd0: begin
                sign_fill   = ~funct3_q[2] & rdata_shifted[7];
                load_result = {{(DATA_WIDTH-8){sign_fill}}, rdata_shifted[7:0]};
            end
            2'd1: begin
                sign_fill   = ~funct3_q[2] & rdata_shifted[15];
                load_result = {{(DATA_WIDTH-16){sign_fill}}, rdata_shifted[15:0]};
            end
            2'd2: begin
                sign_fill   = ~funct3_q[2] & rdata_shifted[31];
                load_result = {{(DATA_WIDTH-32){sign_fill}}, rdata_shifted[31:0]};
            end
            default: begin
                sign_fill   = 1'b0;
                load_result = rdata_shifted;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        o_dmem_req   = 1'b0;
        stall_raw    = 1'b0;
        o_misaligned = 1'b0;
        o_cause      = 4'd0;
        capture      = 1'b0;
        load_capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (misaligned_now) begin
                    o_misaligned = 1'b1;
                    o_cause      = i_mem_we ? 4'd6 : 4'd4;
                end else if (op_valid) begin
                    stall_raw = 1'b1;
                    capture   = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                o_dmem_req = 1'b1;
                stall_raw  = 1'b1;
                if (i_dmem_ready) begin
                    load_capture = ~we_q;
                    state_d      = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
            read_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                addr_q   <= {i_addr[ADDR_WIDTH-1:3], 3'b000};
                be_q     <= be_now;
                wdata_q  <= wdata_now;
                we_q     <= i_mem_we;
                funct3_q <= i_funct3;
                off_q    <= off;
            end
            if (load_capture) begin
                read_data_q <= load_result;
            end
        end
    end

    assign o_stall_mem  = stall_raw & ~i_arst;
    assign o_dmem_we    = o_dmem_req & we_q;
    assign o_dmem_be    = o_dmem_req ? be_q : 8'h00;
    assign o_dmem_addr  = addr_q;
    assign o_dmem_wdata = wdata_q;
    assign o_read_data  = read_data_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed and randomized checks of memory_access_unit against a byte-level
// reference model of alignment, byte enables, store shifting and load extension.
module tb_memory_access_unit;

    logic        clk;
    logic        arst;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] write_data;
    logic        dmem_ready;
    logic [63:0] dmem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [7:0]  dmem_be;
    logic [63:0] dmem_wdata;
    logic [63:0] read_data;
    logic        stall_mem;
    logic        misaligned;
    logic [3:0]  cause;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_rd = '0;

    memory_access_unit dut (
        .i_clk        (clk),
        .i_arst       (arst),
        .i_mem_re     (mem_re),
        .i_mem_we     (mem_we),
        .i_funct3     (funct3),
        .i_addr       (addr),
        .i_write_data (write_data),
        .i_dmem_ready (dmem_ready),
        .i_dmem_rdata (dmem_rdata),
        .o_dmem_req   (dmem_req),
        .o_dmem_we    (dmem_we),
        .o_dmem_addr  (dmem_addr),
        .o_dmem_be    (dmem_be),
        .o_dmem_wdata (dmem_wdata),
        .o_read_data  (read_data),
        .o_stall_mem  (stall_mem),
        .o_misaligned (misaligned),
        .o_cause      (cause),
        .state_dbg    (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_be(input logic [2:0] f3, input logic [63:0] a);
        int sz = 1 << f3[1:0];
        int off = int'(a[2:0]);
        logic [7:0] be = '0;
        for (int i = 0; i < 8; i++)
            if (i >= off && i < off + sz) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [63:0] ref_wdata(input logic [63:0] a, input logic [63:0] d);
        int off = int'(a[2:0]);
        logic [63:0] w = '0;
        for (int i = 0; i < 8; i++)
            if (i >= off) w[8*i +: 8] = d[8*(i-off) +: 8];
        return w;
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a,
                                             input logic [63:0] rd);
        int sz = 1 << f3[1:0];
        int off = int'(a[2:0]);
        logic [63:0] r = '0;
        for (int i = 0; i < sz; i++) r[8*i +: 8] = rd[8*(off+i) +: 8];
        if (!f3[2] && r[8*sz-1])
            for (int i = sz; i < 8; i++) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    task automatic clear_inputs();
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        funct3     = 3'd0;
        addr       = '0;
        write_data = '0;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
    endtask

    // One full access starting from IDLE, just after a clock edge.
    task automatic access(input logic re, input logic we, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] wd,
                          input logic [63:0] rd, input int delay, input string tag);
        int sz = 1 << f3[1:0];
        bit is_op = re | we;
        bit mis = is_op && ((int'(a[2:0]) % sz) != 0);
        logic [63:0] line_addr = {a[63:3], 3'b000};
        mem_re = re; mem_we = we; funct3 = f3; addr = a; write_data = wd;
        dmem_ready = 1'b0; dmem_rdata = {$urandom, $urandom};
        #1;
        if (!is_op) begin
            chk({tag, " nop stall"}, stall_mem, 1'b0);
            chk({tag, " nop mis"}, misaligned, 1'b0);
            tick();
            chk({tag, " nop req"}, dmem_req, 1'b0);
        end else if (mis) begin
            chk({tag, " mis"}, misaligned, 1'b1);
            chk({tag, " cause"}, cause, we ? 4'd6 : 4'd4);
            chk({tag, " mis req"}, dmem_req, 1'b0);
            chk({tag, " mis stall"}, stall_mem, 1'b0);
            tick();
            chk({tag, " mis req2"}, dmem_req, 1'b0);
            chk({tag, " mis stall2"}, stall_mem, 1'b0);
        end else begin
            chk({tag, " idle stall"}, stall_mem, 1'b1);
            chk({tag, " idle mis"}, misaligned, 1'b0);
            chk({tag, " idle req"}, dmem_req, 1'b0);
            tick();
            for (int k = 0; k <= delay; k++) begin
                dmem_ready = (k == delay);
                dmem_rdata = (k == delay) ? rd : {$urandom, $urandom};
                #1;
                chk({tag, " wait req"}, dmem_req, 1'b1);
                chk({tag, " wait stall"}, stall_mem, 1'b1);
                chk({tag, " wait addr"}, dmem_addr, line_addr);
                chk({tag, " wait we"}, dmem_we, we);
                chk({tag, " wait be"}, dmem_be, ref_be(f3, a));
                if (we) chk({tag, " wait wdata"}, dmem_wdata, ref_wdata(a, wd));
                tick();
            end
            dmem_ready = 1'b0;
            dmem_rdata = {$urandom, $urandom};
            #1;
            if (!we) exp_rd = ref_load(f3, a, rd);
            chk({tag, " done stall"}, stall_mem, 1'b0);
            chk({tag, " done req"}, dmem_req, 1'b0);
            chk({tag, " done be"}, dmem_be, 8'h00);
            chk({tag, " done rdata"}, read_data, exp_rd);
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        logic [2:0] f3;
        logic [63:0] a;
        bit re, we;
        clear_inputs();
        arst = 1'b1;
        tick(); tick(); tick();
        chk("reset req", dmem_req, 1'b0);
        chk("reset stall", stall_mem, 1'b0);
        chk("reset rdata", read_data, 64'd0);
        chk("reset be", dmem_be, 8'h00);
        arst = 1'b0;
        tick();

        access(1, 0, 3'd0, 64'h1003, 64'd0, 64'h0000_0000_80FF_0000, 0, "lb");
        chk("lb value", read_data, 64'hFFFF_FFFF_FFFF_FF80);
        access(0, 1, 3'd1, 64'h2006, 64'h1234, 64'd0, 0, "sh");
        access(1, 0, 3'd2, 64'h3002, 64'd0, 64'd0, 0, "lw mis");
        access(0, 1, 3'd3, 64'h3004, 64'd0, 64'd0, 0, "sd mis");
        access(1, 1, 3'd1, 64'h3001, 64'd0, 64'd0, 0, "both mis");
        access(1, 0, 3'd3, 64'h5008, 64'd0, 64'h0123_4567_89AB_CDEF, 5, "ld slow");
        access(1, 0, 3'd7, 64'h5010, 64'd0, 64'h8123_4567_89AB_CDEF, 1, "f3 7");

        // Reset landing in the second WAIT cycle of a load.
        mem_re = 1'b1; funct3 = 3'd3; addr = 64'h4000;
        tick();
        tick();
        chk("rst wait req", dmem_req, 1'b1);
        arst = 1'b1;
        #1;
        chk("rst stall low", stall_mem, 1'b0);
        tick();
        chk("rst req", dmem_req, 1'b0);
        chk("rst rdata", read_data, 64'd0);
        chk("rst stall", stall_mem, 1'b0);
        arst = 1'b0;
        clear_inputs();
        exp_rd = '0;
        tick();
        access(1, 0, 3'd6, 64'h10, 64'd0, 64'h0000_0000_FFFF_FFFF, 0, "lwu");
        chk("lwu value", read_data, 64'h0000_0000_FFFF_FFFF);

        for (int n = 0; n < 60; n++) begin
            re = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~3'((1 << f3[1:0]) - 1);
            access(re, we, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 3), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
